// File: rtl/out_record_collector.sv
// out_record_collector: reassembles 16 cipher + 32 tag bytes into records and queues them for the host.
module out_record_collector #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    output logic [127:0]     o_cipher,
    output logic [255:0]     o_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_count,
    output logic             o_err,
    output logic             o_ovf
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {WAIT_C, CIPH, WAIT_T, TAG} state_t;

    state_t       state, state_d;
    logic [4:0]   bcnt, bcnt_d;
    logic         wr_c, wr_t, push, brk;
    logic [127:0] cipher;
    logic [255:0] tag;
    logic [127:0] cmem [DEPTH];
    logic [255:0] tmem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         full, pop, acc;

    always_comb begin
        state_d = state;
        bcnt_d  = bcnt;
        wr_c    = 1'b0;
        wr_t    = 1'b0;
        push    = 1'b0;
        brk     = 1'b0;
        case (state)
            WAIT_C: if (i_valid) begin
                wr_c    = 1'b1;
                bcnt_d  = 5'd1;
                state_d = CIPH;
            end
            CIPH: if (i_valid) begin
                wr_c    = 1'b1;
                bcnt_d  = (bcnt == 5'd15) ? 5'd0 : bcnt + 5'd1;
                state_d = (bcnt == 5'd15) ? WAIT_T : CIPH;
            end else begin
                brk     = 1'b1;
                bcnt_d  = 5'd0;
                state_d = WAIT_C;
            end
            WAIT_T: if (i_valid) begin
                wr_t    = 1'b1;
                bcnt_d  = 5'd1;
                state_d = TAG;
            end
            TAG: if (i_valid) begin
                wr_t    = 1'b1;
                push    = (bcnt == 5'd31);
                bcnt_d  = bcnt + 5'd1;
                state_d = (bcnt == 5'd31) ? WAIT_C : TAG;
            end else begin
                brk     = 1'b1;
                bcnt_d  = 5'd0;
                state_d = WAIT_C;
            end
            default: state_d = WAIT_C;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= WAIT_C;
            bcnt  <= 5'd0;
        end else begin
            state <= state_d;
            bcnt  <= bcnt_d;
        end
    end

    // Partial records need no clearing: every byte is rewritten before the next push.
    always_ff @(posedge clk) begin
        if (wr_c) cipher[{bcnt[3:0], 3'b000} +: 8] <= i_data;
        if (wr_t) tag[{bcnt, 3'b000} +: 8] <= i_data;
    end

    assign o_valid  = (wp != rp);
    assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop      = o_valid && i_ready;
    assign acc      = push && (!full || pop);
    assign o_cipher = cmem[rp[AW-1:0]];
    assign o_tag    = tmem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cmem[i] <= '0;
                tmem[i] <= '0;
            end
            wp      <= '0;
            rp      <= '0;
            o_count <= '0;
            o_err   <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            if (acc) begin
                cmem[wp[AW-1:0]] <= cipher;
                tmem[wp[AW-1:0]] <= {i_data, tag[247:0]};
                wp               <= wp + (AW+1)'(1);
            end
            if (pop) begin
                rp      <= rp + (AW+1)'(1);
                o_count <= o_count + CNT_W'(1);
            end
            o_err <= brk;
            o_ovf <= push && full && !pop;
        end
    end
endmodule

// File: tb/tb_out_record_collector.sv
// tb_out_record_collector: byte-count/queue reference model checked every cycle, plus hand-computed spot checks.
module tb_out_record_collector;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   i_data = 8'h00;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b1;
    logic [127:0] o_cipher;
    logic [255:0] o_tag;
    logic         o_valid;
    logic [7:0]   o_count;
    logic         o_err;
    logic         o_ovf;

    int checks = 0;
    int errors = 0;

    out_record_collector #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_cipher(o_cipher), .o_tag(o_tag), .o_valid(o_valid), .i_ready(i_ready),
        .o_count(o_count), .o_err(o_err), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a record is 16 contiguous bytes, any gap, then 32 contiguous bytes.
    logic [383:0] mq[$];
    logic [7:0]   bytes[48];
    int           nb = 0;
    logic [7:0]   cnt_exp = 8'h00;
    logic         err_exp = 1'b0, ovf_exp = 1'b0, zero_exp = 1'b1;

    always @(posedge clk) begin
        bit done, pop;
        logic [383:0] r;
        if (!rst_n) begin
            mq.delete();
            nb = 0; cnt_exp = 8'h00; err_exp = 1'b0; ovf_exp = 1'b0; zero_exp = 1'b1;
        end else begin
            pop = (mq.size() > 0) && i_ready;
            done = 1'b0; err_exp = 1'b0; ovf_exp = 1'b0;
            if (i_valid) begin
                bytes[nb] = i_data;
                nb++;
                if (nb == 48) begin done = 1'b1; nb = 0; end
            end else if (nb != 0 && nb != 16) begin
                err_exp = 1'b1;
                nb = 0;
            end
            if (pop) begin void'(mq.pop_front()); cnt_exp++; end
            if (done) begin
                for (int k = 0; k < 16; k++) r[256 + 8*k +: 8] = bytes[k];
                for (int k = 0; k < 32; k++) r[8*k +: 8] = bytes[16 + k];
                if (mq.size() < DEPTH) begin mq.push_back(r); zero_exp = 1'b0; end
                else ovf_exp = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("o_valid", 384'(o_valid), 384'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("o_cipher", 384'(o_cipher), 384'(mq[0][383:256]));
            chk("o_tag", 384'(o_tag), 384'(mq[0][255:0]));
        end else if (zero_exp) begin
            chk("o_cipher_zero", 384'(o_cipher), 384'(0));
            chk("o_tag_zero", 384'(o_tag), 384'(0));
        end
        chk("o_count", 384'(o_count), 384'(cnt_exp));
        chk("o_err", 384'(o_err), 384'(err_exp));
        chk("o_ovf", 384'(o_ovf), 384'(ovf_exp));
    end

    task automatic send_bytes(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data  = base + 8'(k);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic send_rec(input logic [7:0] base, input int gap);
        send_bytes(base, 16);
        idle(gap);
        send_bytes(base + 8'd16, 32);
    endtask

    localparam logic [127:0] NOM_C = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [255:0] NOM_T = 256'h2F2E2D2C2B2A292827262524232221201F1E1D1C1B1A19181716151413121110;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_valid", 384'(o_valid), 384'(0));
        chk("reset_count", 384'(o_count), 384'(0));
        rst_n = 1'b1;

        send_rec(8'h00, 1);
        @(negedge clk);
        i_valid = 1'b0;
        chk("nom_valid", 384'(o_valid), 384'(1));
        chk("nom_cipher", 384'(o_cipher), 384'(NOM_C));
        chk("nom_tag", 384'(o_tag), 384'(NOM_T));
        idle(2);
        chk("nom_count", 384'(o_count), 384'(1));
        chk("nom_drained", 384'(o_valid), 384'(0));

        send_rec(8'h00, 0);
        @(negedge clk);
        i_valid = 1'b0;
        chk("zg_cipher", 384'(o_cipher), 384'(NOM_C));
        chk("zg_tag", 384'(o_tag), 384'(NOM_T));
        idle(2);

        send_bytes(8'h50, 8);
        idle(1);
        @(negedge clk);
        chk("cbrk_err", 384'(o_err), 384'(1));
        send_rec(8'h00, 1);
        idle(3);
        chk("cbrk_count", 384'(o_count), 384'(3));

        send_bytes(8'h60, 16);
        idle(1);
        send_bytes(8'h70, 21);
        idle(1);
        @(negedge clk);
        chk("tbrk_err", 384'(o_err), 384'(1));
        send_rec(8'h00, 1);
        idle(3);
        chk("tbrk_count", 384'(o_count), 384'(4));

        i_ready = 1'b0;
        send_rec(8'h40, 1);
        send_rec(8'h80, 1);
        send_rec(8'hC0, 1);
        @(negedge clk);
        i_valid = 1'b0;
        chk("ovf_pulse", 384'(o_ovf), 384'(1));
        idle(2);
        i_ready = 1'b1;
        idle(4);
        chk("ovf_count", 384'(o_count), 384'(6));

        i_ready = 1'b0;
        send_rec(8'h40, 1);
        send_rec(8'h80, 1);
        send_bytes(8'hC0, 16);
        idle(1);
        send_bytes(8'hD0, 31);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 8'hEF;
        i_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("fp_no_ovf", 384'(o_ovf), 384'(0));
        chk("fp_count", 384'(o_count), 384'(7));
        idle(2);
        i_ready = 1'b1;
        idle(4);
        chk("fp_drain_count", 384'(o_count), 384'(9));

        i_ready = 1'b0;
        send_rec(8'h40, 1);
        send_bytes(8'h80, 16);
        idle(1);
        send_bytes(8'h90, 11);
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'hAA;
        @(negedge clk);
        rst_n   = 1'b1;
        i_valid = 1'b0;
        chk("rst_valid", 384'(o_valid), 384'(0));
        chk("rst_cipher", 384'(o_cipher), 384'(0));
        chk("rst_tag", 384'(o_tag), 384'(0));
        chk("rst_count", 384'(o_count), 384'(0));
        i_ready = 1'b1;
        send_rec(8'h00, 1);
        @(negedge clk);
        i_valid = 1'b0;
        chk("rst_cipher_after", 384'(o_cipher), 384'(NOM_C));
        idle(3);
        chk("rst_count_after", 384'(o_count), 384'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
